// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit opcode constants (same encoding as the old combinational ALU)
//   - FSM state encoding
//   - is_shift(): true for the serial shift/rotate opcodes (0xA..0xF)
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ID   = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_LRS  = 4'hA;
  localparam logic [3:0] OP_ARS  = 4'hB;
  localparam logic [3:0] OP_RR   = 4'hC;
  localparam logic [3:0] OP_LLS  = 4'hD;
  localparam logic [3:0] OP_ALS  = 4'hE;
  localparam logic [3:0] OP_RL   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return op >= OP_LRS;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result channel of the sequential ALU.
//   Input side : in_valid, in_ready, A, B, Cin, OP
//   Output side: out_valid, out_ready, C, Cout, N, Z, V
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds its payload stable while valid is high and not yet
// accepted; the ALU holds C/Cout/N/Z/V stable while out_valid && !out_ready.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [3:0]       OP;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             Cout;
  logic             N;
  logic             Z;
  logic             V;

  modport master (
    output in_valid, A, B, Cin, OP, out_ready,
    input  in_ready, out_valid, C, Cout, N, Z, V
  );

  modport slave (
    input  in_valid, A, B, Cin, OP, out_ready,
    output in_ready, out_valid, C, Cout, N, Z, V
  );
endinterface

// File: rtl/alu_shift_step.sv
// alu_shift_step: one 1-bit step of a shift/rotate (combinational).
//   op          : shift opcode (LRS/ARS/RR/LLS/ALS/RL); others pass value through
//   value       : current work value
//   next_value  : value after the step
//   out_bit     : bit shifted out (lsb for right moves, msb for left moves)
//   msb_changed : the step altered the msb (used for ALS overflow)
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit,
  output logic             msb_changed
);

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      OP_LRS: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_ARS: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_RR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      OP_LLS, OP_ALS: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        out_bit    = value[WIDTH-1];
      end
      OP_RL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      default: ;
    endcase
    msb_changed = next_value[WIDTH-1] != value[WIDTH-1];
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with serial (1 bit/cycle) shift and rotate.
//   clk, reset : clock and synchronous active-high reset
//   bus        : alu_seq_if slave (operands in, result + N/Z/V/Cout out)
//   dbg_state  : current FSM state, for observation only
// Non-shift ops and zero-amount shifts finish in one cycle; a shift by n>0
// spends n cycles in SHIFT using the C register as the work register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus,
  output state_t      dbg_state
);

  localparam int MSB = WIDTH - 1;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     c_q;
  logic                 cout_q, n_q, z_q, v_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [3:0]           op_q;

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH:0]       sum_w, diff_w;
  logic [WIDTH-1:0]     res;
  logic                 res_co, res_v;
  logic [WIDTH-1:0]     step_val;
  logic                 step_out, step_msb_chg;

  assign shamt = bus.B[SHAMT_W-1:0];

  // Single-cycle result. Shift opcodes yield A here: that is both the final
  // answer for n==0 and the initial work value for n>0.
  always_comb begin
    sum_w  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    diff_w = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, ~bus.Cin};
    res    = bus.A;
    res_co = 1'b0;
    res_v  = 1'b0;
    case (bus.OP)
      OP_ADD: begin
        res    = sum_w[MSB:0];
        res_co = sum_w[WIDTH];
        res_v  = (bus.A[MSB] == bus.B[MSB]) && (sum_w[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        res    = diff_w[MSB:0];
        res_co = diff_w[WIDTH];
        res_v  = (bus.A[MSB] != bus.B[MSB]) && (diff_w[MSB] != bus.A[MSB]);
      end
      OP_ID:   res = bus.A;
      OP_NAND: res = ~(bus.A & bus.B);
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_XNOR: res = ~(bus.A ^ bus.B);
      OP_NOT:  res = ~bus.A;
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_XOR:  res = bus.A ^ bus.B;
      default: ;
    endcase
  end

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .op          (op_q),
    .value       (c_q),
    .next_value  (step_val),
    .out_bit     (step_out),
    .msb_changed (step_msb_chg)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_shift(bus.OP) && (shamt != '0)) state_nx = ST_SHIFT;
          else                                   state_nx = ST_DONE;
        end
      end
      ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_nx = ST_DONE;
      ST_DONE:  if (bus.out_ready)        state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      cout_q <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            c_q    <= res;
            cout_q <= res_co;
            v_q    <= res_v;
            n_q    <= res[MSB];
            z_q    <= (res == '0);
            op_q   <= bus.OP;
            cnt_q  <= shamt;
          end
        end
        ST_SHIFT: begin
          c_q    <= step_val;
          cout_q <= step_out;
          // ALS overflow is sticky across all steps of the shift.
          v_q    <= v_q | ((op_q == OP_ALS) && step_msb_chg);
          n_q    <= step_val[MSB];
          z_q    <= (step_val == '0);
          cnt_q  <= cnt_q - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.C         = c_q;
  assign bus.Cout      = cout_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign dbg_state     = state;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 16-bit combinational ALU.
- Keeps the same 16-op 4-bit opcode set.
- Adds:
  - generic WIDTH;
  - multi-bit shift and rotate by an amount, executed serially one bit per cycle;
  - N/Z/V status flags;
  - a registered result held under valid/ready backpressure.
- Sits between the register-file read stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 16, operand/result width; must be at least 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from B[SHAMT_W-1:0].

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shift/rotate ops only B[SHAMT_W-1:0] is used, as the amount n.
- Cin  in  1  carry-in (ADD) or borrow-in (SUB).
- OP  in  4  opcode:
  - ADD=0, SUB=1, ID=2, NAND=3, NOR=4, XNOR=5, NOT=6, AND=7
  - OR=8, XOR=9, LRS=A, ARS=B, RR=C, LLS=D, ALS=E, RL=F
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes the result.
- C  out  WIDTH  result.
- Cout  out  1  carry/borrow or last bit shifted out.
- N  out  1  C[WIDTH-1].
- Z  out  1  C equals 0.
- V  out  1  signed overflow.

Behaviour:
- Reset, when reset=1 at an edge:
  - state goes to IDLE;
  - C=0, Cout=0, N=0, Z=0, V=0, out_valid=0, shift counter=0;
  - reset overrides everything, including mid-SHIFT and DONE-with-backpressure; the in-flight op is discarded.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE); out_valid = (state==DONE).
- Accept: an edge with in_valid && in_ready latches A, B, Cin, OP.
- IDLE, non-shift op (OP<=9):
  - result and flags are computed combinationally and registered on the accept edge;
  - next state is DONE, so out_valid is high on the cycle after accept (latency 1).
- IDLE, shift op (OP>=A) with n = B[SHAMT_W-1:0]:
  - n==0: C=A, Cout=0, V=0; go to DONE (latency 1);
  - n>0: work register = A, counter = n; go to SHIFT.
- SHIFT:
  - each edge applies one 1-bit step to the work register, sets Cout to the bit shifted out by that step, and decrements the counter;
  - when the counter goes 1 -> 0, go to DONE;
  - out_valid rises n+1 cycles after the accept edge.
- DONE:
  - C, Cout, N, Z and V are held stable while out_ready=0;
  - an edge with out_ready=1 returns to IDLE;
  - no new accept occurs on that same edge (in_ready was low), giving at most one op every 2 cycles.
- Arithmetic, computed WIDTH+1 bits wide:
  - ADD: {Cout,C} = A + B + Cin; V = (A[msb]==B[msb]) && (C[msb]!=A[msb]).
  - SUB: {Cout,C} = A + ~B + !Cin, i.e. C = A-B-Cin; Cout=1 means no borrow; V = (A[msb]!=B[msb]) && (C[msb]!=A[msb]).
- Logic ops (ID..XOR): bitwise, as named; NOT and ID use A only; Cout=0, V=0.
- Shift steps:
  - LRS: zero in at msb; ARS: replicate msb; RR: lsb wraps to msb; Cout = lsb before the step.
  - LLS/ALS: zero in at lsb; RL: msb wraps to lsb; Cout = msb before the step.
  - ALS only: V is sticky-set if any step changes the msb; V=0 for all other shifts.
- Flags: N and Z always derive from the final C, for every op.
- Inputs are ignored while not in IDLE.

Decomposition:
- Package alu_pkg holds:
  - the 16 opcode localparams;
  - the state encoding (IDLE/SHIFT/DONE);
  - an is_shift(op) function.
- Sub-module alu_shift_step (combinational, parameter WIDTH):
  - inputs: op, value;
  - outputs: next value, shifted-out bit, msb_changed;
  - instantiated once in the SHIFT datapath.

Test Plan (WIDTH=16):
- ADD A=0xFFFF B=0x0001 Cin=0 -> C=0x0000, Cout=1, Z=1, N=0, V=0; out_valid exactly 1 cycle after accept.
- SUB A=0x8000 B=0x0001 Cin=0 -> C=0x7FFF, Cout=1, V=1, N=0; then SUB A=0x0000 B=0x0001 Cin=1 -> C=0xFFFE, Cout=0, N=1.
- ARS A=0x8004 B=0x0003 -> C=0xF000, Cout=1, V=0; in_ready low for 4 cycles and out_valid 4 cycles after accept. Also RL A=0x8001 B=0x0014 (n=4) -> C=0x0018, Cout=0.
- ALS A=0x4000 B=0x0001 -> C=0x8000, V=1, N=1; LRS with B=0x0010 (n=0) -> C=A, Cout=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands toggling -> C and flags unchanged, in_ready=0, no second op accepted; out_ready=1 -> IDLE next cycle.
- Reset asserted on the 2nd SHIFT cycle of an RR with n=15 -> next cycle IDLE, out_valid=0, C=0, all flags 0, in_ready=1; a following ADD completes normally.
